washroom_stall_scheduler: RTL and testbench

- Multi-stall controller for the smart restroom system.
- Assigns arriving users to vacant stalls by round-robin and sequences each stall's door, light and vacancy indicator through entry, use, mandatory flush and exit.
- Owns the shared water tank model: flush arbitration, level accounting and refill-motor control for the owner.
- Sits between the entrance kiosk/button panel and the per-stall door actuators and lights.

---
 rtl/washroom_stall_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_washroom_stall_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/washroom_stall_scheduler.sv
// Multi-stall restroom controller: round-robin stall admission, per-stall door/light
// sequencing, and a shared water tank with flush arbitration and hysteretic refill.
module washroom_stall_scheduler #(
  parameter int N_STALLS    = 4,
  parameter int ID_W        = 2,
  parameter int DOOR_HOLD   = 3,
  parameter int LVL_W       = 8,
  parameter int TANK_MAX    = 20,
  parameter int LOW_MARK    = 8,
  parameter int FLUSH_COST  = 6,
  parameter int REFILL_RATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                entry_req,
  output logic                entry_ack,
  output logic [ID_W-1:0]     entry_grant_id,
  output logic                entry_reject,
  input  logic [N_STALLS-1:0] flush_btn,
  input  logic [N_STALLS-1:0] exit_btn,
  output logic [N_STALLS-1:0] door_open,
  output logic [N_STALLS-1:0] light,
  output logic [N_STALLS-1:0] vacant,
  output logic [N_STALLS-1:0] flush_done,
  output logic [N_STALLS-1:0] flush_denied,
  output logic                motor_on,
  output logic [LVL_W-1:0]    water_level
);

  typedef enum logic [2:0] {
    ST_VACANT,
    ST_ENTER,
    ST_OCCUPIED,
    ST_FLUSHED,
    ST_EXIT
  } stall_state_t;

  localparam int HOLD_W = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(DOOR_HOLD - 1);
  localparam logic [LVL_W:0]    TANK_MAX_X = (LVL_W+1)'(TANK_MAX);
  localparam logic [LVL_W:0]    COST_X     = (LVL_W+1)'(FLUSH_COST);
  localparam logic [LVL_W:0]    RATE_X     = (LVL_W+1)'(REFILL_RATE);
  localparam logic [LVL_W-1:0]  LOW_MARK_L = LVL_W'(LOW_MARK);
  localparam logic [LVL_W-1:0]  COST_L     = LVL_W'(FLUSH_COST);

  logic [ID_W-1:0]     ptr_reg;
  logic [ID_W-1:0]     grant_id_reg;
  logic                ack_reg;
  logic                reject_reg;
  logic                motor_reg;
  logic [LVL_W-1:0]    level_reg;

  logic [N_STALLS-1:0] stall_is_vacant;
  logic [N_STALLS-1:0] flush_elig;
  logic [N_STALLS-1:0] flush_win;
  logic [N_STALLS-1:0] flush_exec;
  logic [N_STALLS-1:0] flush_deny;
  logic [N_STALLS-1:0] grant_onehot;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand_id;
  logic                do_grant;
  logic                flush_any;
  logic                flush_ok;
  logic [LVL_W:0]      level_sum;
  logic [LVL_W-1:0]    level_next;

  // Search upward from pointer+1 with wrap; first vacant stall wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_id     = '0;
    for (int k = 1; k <= N_STALLS; k++) begin
      cand_id = ID_W'((int'(ptr_reg) + k) % N_STALLS);
      if (!grant_found && stall_is_vacant[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  assign do_grant = entry_req && !motor_reg && grant_found;

  always_comb begin
    flush_any = 1'b0;
    flush_win = '0;
    for (int i = 0; i < N_STALLS; i++) begin
      if (!flush_any && flush_elig[i]) begin
        flush_win[i] = 1'b1;
        flush_any    = 1'b1;
      end
    end
  end

  assign flush_ok   = flush_any && (level_reg >= COST_L);
  assign flush_exec = flush_ok ? flush_win : '0;
  assign flush_deny = flush_ok ? '0 : flush_win;

  // Extra headroom bit lets the refill overshoot before clamping at full.
  always_comb begin
    level_sum = {1'b0, level_reg};
    if (flush_ok) level_sum = level_sum - COST_X;
    if (motor_reg) level_sum = level_sum + RATE_X;
    level_next = (level_sum > TANK_MAX_X) ? LVL_W'(TANK_MAX) : level_sum[LVL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg      <= 1'b0;
      reject_reg   <= 1'b0;
      grant_id_reg <= '0;
      ptr_reg      <= ID_W'(N_STALLS - 1);
      level_reg    <= LVL_W'(TANK_MAX);
      motor_reg    <= 1'b0;
    end else begin
      ack_reg    <= do_grant;
      reject_reg <= entry_req && !do_grant;
      if (do_grant) begin
        grant_id_reg <= grant_idx;
        ptr_reg      <= grant_idx;
      end
      level_reg <= level_next;
      if (level_reg < LOW_MARK_L)
        motor_reg <= 1'b1;
      else if (level_reg == LVL_W'(TANK_MAX))
        motor_reg <= 1'b0;
    end
  end

  assign entry_ack      = ack_reg;
  assign entry_reject   = reject_reg;
  assign entry_grant_id = grant_id_reg;
  assign motor_on       = motor_reg;
  assign water_level    = level_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_STALLS; gi++) begin : g_stall
      stall_state_t      state_reg;
      logic [HOLD_W-1:0] hold_reg;
      logic              door_reg;
      logic              light_reg;
      logic              vacant_reg;
      logic              done_reg;
      logic              denied_reg;

      assign grant_onehot[gi]    = do_grant && (grant_idx == ID_W'(gi));
      assign stall_is_vacant[gi] = (state_reg == ST_VACANT);
      assign flush_elig[gi]      = flush_btn[gi] &&
                                   ((state_reg == ST_OCCUPIED) || (state_reg == ST_FLUSHED));

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg  <= ST_VACANT;
          hold_reg   <= '0;
          door_reg   <= 1'b0;
          light_reg  <= 1'b0;
          vacant_reg <= 1'b1;
          done_reg   <= 1'b0;
          denied_reg <= 1'b0;
        end else begin
          done_reg   <= flush_exec[gi];
          denied_reg <= flush_deny[gi];
          case (state_reg)
            ST_VACANT: begin
              if (grant_onehot[gi]) begin
                state_reg  <= ST_ENTER;
                hold_reg   <= HOLD_LOAD;
                door_reg   <= 1'b1;
                light_reg  <= 1'b1;
                vacant_reg <= 1'b0;
              end
            end
            ST_ENTER: begin
              if (hold_reg == '0) begin
                state_reg <= ST_OCCUPIED;
                door_reg  <= 1'b0;
              end else begin
                hold_reg <= hold_reg - HOLD_W'(1);
              end
            end
            ST_OCCUPIED: begin
              if (flush_exec[gi]) state_reg <= ST_FLUSHED;
            end
            ST_FLUSHED: begin
              if (exit_btn[gi]) begin
                state_reg <= ST_EXIT;
                hold_reg  <= HOLD_LOAD;
                door_reg  <= 1'b1;
                light_reg <= 1'b0;
              end
            end
            ST_EXIT: begin
              if (hold_reg == '0) begin
                state_reg  <= ST_VACANT;
                door_reg   <= 1'b0;
                vacant_reg <= 1'b1;
              end else begin
                hold_reg <= hold_reg - HOLD_W'(1);
              end
            end
            default: begin
              state_reg  <= ST_VACANT;
              door_reg   <= 1'b0;
              light_reg  <= 1'b0;
              vacant_reg <= 1'b1;
            end
          endcase
        end
      end

      assign door_open[gi]    = door_reg;
      assign light[gi]        = light_reg;
      assign vacant[gi]       = vacant_reg;
      assign flush_done[gi]   = done_reg;
      assign flush_denied[gi] = denied_reg;
    end
  endgenerate

endmodule

// File: tb/tb_washroom_stall_scheduler.sv
// Directed bench for washroom_stall_scheduler: admission, door timing, flush arbitration,
// tank/motor hysteresis, round-robin wrap and mid-operation reset.
module tb_washroom_stall_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_req;
  logic       entry_ack;
  logic [1:0] entry_grant_id;
  logic       entry_reject;
  logic [3:0] flush_btn;
  logic [3:0] exit_btn;
  logic [3:0] door_open;
  logic [3:0] light;
  logic [3:0] vacant;
  logic [3:0] flush_done;
  logic [3:0] flush_denied;
  logic       motor_on;
  logic [7:0] water_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  washroom_stall_scheduler #(
    .N_STALLS(4), .ID_W(2), .DOOR_HOLD(3), .LVL_W(8),
    .TANK_MAX(20), .LOW_MARK(8), .FLUSH_COST(6), .REFILL_RATE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .entry_req(entry_req),
    .entry_ack(entry_ack),
    .entry_grant_id(entry_grant_id),
    .entry_reject(entry_reject),
    .flush_btn(flush_btn),
    .exit_btn(exit_btn),
    .door_open(door_open),
    .light(light),
    .vacant(vacant),
    .flush_done(flush_done),
    .flush_denied(flush_denied),
    .motor_on(motor_on),
    .water_level(water_level)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] door_seq [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] vac_seq  [5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};

  initial begin
    rst = 1'b1; entry_req = 1'b0; flush_btn = '0; exit_btn = '0;
    tick(); tick();
    check_val("rst_vacant", vacant, 4'b1111);
    check_val("rst_door", door_open, 4'b0000);
    check_val("rst_light", light, 4'b0000);
    check_val("rst_level", water_level, 20);
    check_val("rst_motor", motor_on, 0);
    check_val("rst_ack", entry_ack, 0);
    check_val("rst_reject", entry_reject, 0);
    check_val("rst_id", entry_grant_id, 0);
    check_val("rst_fdone", flush_done, 0);
    check_val("rst_fdeny", flush_denied, 0);
    rst = 1'b0;

    // Five back-to-back requests: four grants then a reject.
    entry_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        check_val($sformatf("s1_ack%0d", i), entry_ack, 1);
        check_val($sformatf("s1_id%0d", i), entry_grant_id, i);
        check_val($sformatf("s1_rej%0d", i), entry_reject, 0);
      end else begin
        check_val("s1_ack4", entry_ack, 0);
        check_val("s1_rej4", entry_reject, 1);
        check_val("s1_idhold", entry_grant_id, 3);
      end
      check_val($sformatf("s1_door%0d", i), door_open, door_seq[i]);
      check_val($sformatf("s1_vac%0d", i), vacant, vac_seq[i]);
    end
    entry_req = 1'b0;
    for (int i = 5; i < 7; i++) begin
      tick();
      check_val($sformatf("s1_door%0d", i), door_open, door_seq[i]);
      if (i == 5) check_val("s1_rej_clear", entry_reject, 0);
    end
    check_val("s1_light", light, 4'b1111);

    // Exit without flush is ignored; flush then exit stall 1.
    exit_btn = 4'b0010;
    tick();
    check_val("s2_noexit_door", door_open, 4'b0000);
    check_val("s2_noexit_vac", vacant, 4'b0000);
    exit_btn = 4'b0000; flush_btn = 4'b0010;
    tick();
    check_val("s2_fdone", flush_done, 4'b0010);
    check_val("s2_level", water_level, 14);
    flush_btn = 4'b0000;
    tick();
    check_val("s2_fdone_pulse", flush_done, 4'b0000);
    exit_btn = 4'b0010;
    tick();
    check_val("s2_exit_door", door_open, 4'b0010);
    check_val("s2_exit_light", light, 4'b1101);
    check_val("s2_exit_vac", vacant, 4'b0000);
    exit_btn = 4'b0000;
    tick(); tick();
    check_val("s2_exit_door3", door_open, 4'b0010);
    tick();
    check_val("s2_closed", door_open, 4'b0000);
    check_val("s2_vac", vacant, 4'b0010);

    // Fresh start: stalls 0-2 occupied, simultaneous flushes.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    entry_req = 1'b1;
    tick(); tick(); tick();
    check_val("s3_id2", entry_grant_id, 2);
    entry_req = 1'b0;
    tick(); tick(); tick(); tick();
    check_val("s3_door", door_open, 4'b0000);
    check_val("s3_vac", vacant, 4'b1000);
    flush_btn = 4'b0111;
    tick();
    check_val("s3_fdone0", flush_done, 4'b0001);
    check_val("s3_lvl14", water_level, 14);
    flush_btn = 4'b0110;
    tick();
    check_val("s3_fdone1", flush_done, 4'b0010);
    check_val("s3_lvl8", water_level, 8);
    flush_btn = 4'b0100;
    tick();
    check_val("s3_fdone2", flush_done, 4'b0100);
    check_val("s3_lvl2", water_level, 2);
    check_val("s3_motor_off", motor_on, 0);
    flush_btn = 4'b0000;
    tick();
    check_val("s3_motor_on", motor_on, 1);
    check_val("s3_lvl2_hold", water_level, 2);

    // Refill in progress: rejects, denied flush, climb to full.
    entry_req = 1'b1;
    tick();
    check_val("s4_reject", entry_reject, 1);
    check_val("s4_noack", entry_ack, 0);
    check_val("s4_lvl3", water_level, 3);
    entry_req = 1'b0; flush_btn = 4'b0001;
    tick();
    check_val("s4_fdeny", flush_denied, 4'b0001);
    check_val("s4_fdone", flush_done, 4'b0000);
    check_val("s4_lvl4", water_level, 4);
    flush_btn = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val($sformatf("s4_lvl%0d", 5 + i), water_level, 5 + i);
    end
    check_val("s4_motor_still", motor_on, 1);
    tick();
    check_val("s4_motor_clear", motor_on, 0);
    check_val("s4_lvl_sat", water_level, 20);
    entry_req = 1'b1;
    tick();
    check_val("s4_ack", entry_ack, 1);
    check_val("s4_id3", entry_grant_id, 3);
    entry_req = 1'b0;

    // Release stalls 0 and 3 so the pointer (3) must wrap to 0, then reach 3.
    tick(); tick(); tick();
    check_val("s5_door", door_open, 4'b0000);
    flush_btn = 4'b1000;
    tick();
    check_val("s5_fdone3", flush_done, 4'b1000);
    check_val("s5_lvl14", water_level, 14);
    flush_btn = 4'b0000; exit_btn = 4'b1001;
    tick();
    check_val("s5_exit_door", door_open, 4'b1001);
    check_val("s5_exit_light", light, 4'b0110);
    exit_btn = 4'b0000;
    tick(); tick(); tick();
    check_val("s5_vac", vacant, 4'b1001);
    entry_req = 1'b1;
    tick();
    check_val("s5_ack0", entry_ack, 1);
    check_val("s5_wrap_id0", entry_grant_id, 0);
    tick();
    check_val("s5_ack1", entry_ack, 1);
    check_val("s5_id3", entry_grant_id, 3);
    check_val("s5_norej", entry_reject, 0);
    entry_req = 1'b0;

    // Reset while stall 2 has its exit door open.
    tick(); tick(); tick(); tick();
    check_val("s6_door_idle", door_open, 4'b0000);
    exit_btn = 4'b0100;
    tick();
    check_val("s6_exit_door", door_open, 4'b0100);
    exit_btn = 4'b0000; rst = 1'b1;
    tick();
    check_val("s6_door", door_open, 4'b0000);
    check_val("s6_vac", vacant, 4'b1111);
    check_val("s6_light", light, 4'b0000);
    check_val("s6_level", water_level, 20);
    check_val("s6_motor", motor_on, 0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
